// File: rtl/fetch_unit_if.sv
// fetch_unit_if: instruction-memory request/response channel
// and the decode-side valid/ready channel of the fetch unit.
interface fetch_unit_if #(
  parameter int XLEN = 32,
  parameter int ILEN = 32
);
  logic            imem_req_valid;
  logic            imem_req_ready;
  logic [XLEN-1:0] imem_req_addr;
  logic            imem_rsp_valid;
  logic [ILEN-1:0] imem_rsp_data;
  logic            out_valid;
  logic            out_ready;
  logic [ILEN-1:0] out_instr;
  logic [XLEN-1:0] out_pc;

  modport master (
    output imem_req_valid,
    output imem_req_addr,
    input  imem_req_ready,
    input  imem_rsp_valid,
    input  imem_rsp_data,
    output out_valid,
    output out_instr,
    output out_pc,
    input  out_ready
  );

  modport slave (
    input  imem_req_valid,
    input  imem_req_addr,
    output imem_req_ready,
    output imem_rsp_valid,
    output imem_rsp_data,
    input  out_valid,
    input  out_instr,
    input  out_pc,
    output out_ready
  );
endinterface

// File: rtl/fetch_unit.sv
// fetch_unit: fetch PC, pipelined imem requests, prefetch FIFO,
// and redirect flush that drops responses from the old path.
module fetch_unit #(
  parameter int              XLEN            = 32,
  parameter int              ILEN            = 32,
  parameter logic [XLEN-1:0] RESET_PC        = '0,
  parameter int              FIFO_DEPTH      = 4,
  parameter int              MAX_OUTSTANDING = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  fetch_unit_if.master    bus,
  output logic            err
);

  localparam int CW = $clog2(MAX_OUTSTANDING + 1);
  localparam int FW = $clog2(FIFO_DEPTH + 1);
  localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam logic [XLEN-1:0] PC_STEP = XLEN'(4);
  localparam logic [XLEN-1:0] PC_MASK = ~XLEN'(3);

  logic [XLEN-1:0] fetch_pc_q, fetch_pc_d;
  logic [XLEN-1:0] rsp_pc_q, rsp_pc_d;
  logic [CW-1:0]   outstanding_q, outstanding_d;
  logic [CW-1:0]   drop_cnt_q, drop_cnt_d;
  logic [CW-1:0]   live;
  logic [FW-1:0]   fifo_count_q, fifo_count_d;
  logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
  logic            err_q, err_d;

  logic [ILEN-1:0] instr_mem_q [FIFO_DEPTH];
  logic [XLEN-1:0] pc_mem_q    [FIFO_DEPTH];

  logic            credit;
  logic            req_fire;
  logic            rsp_ok;
  logic            rsp_stray;
  logic            push;
  logic            pop;
  logic [XLEN-1:0] redirect_base;

  // Credit: never request more than the FIFO can absorb.
  always_comb begin
    live   = outstanding_q - drop_cnt_q;
    credit = ((32'(fifo_count_q) + 32'(live))
               < 32'(FIFO_DEPTH))
          && (32'(outstanding_q)
               < 32'(MAX_OUTSTANDING));
  end

  assign redirect_base      = redirect_pc & PC_MASK;
  assign bus.imem_req_valid = credit
                           && !redirect_valid
                           && !rst;
  assign bus.imem_req_addr  = fetch_pc_q;
  assign bus.out_valid      = (fifo_count_q != '0)
                           && !redirect_valid
                           && !rst;
  assign bus.out_instr      = instr_mem_q[rd_ptr_q];
  assign bus.out_pc         = pc_mem_q[rd_ptr_q];
  assign err                = err_q;

  // Next-state: issue, response accounting, FIFO, redirect.
  always_comb begin
    fetch_pc_d    = fetch_pc_q;
    rsp_pc_d      = rsp_pc_q;
    outstanding_d = outstanding_q;
    drop_cnt_d    = drop_cnt_q;
    fifo_count_d  = fifo_count_q;
    rd_ptr_d      = rd_ptr_q;
    wr_ptr_d      = wr_ptr_q;
    err_d         = err_q;
    push          = 1'b0;

    req_fire  = bus.imem_req_valid
             && bus.imem_req_ready;
    rsp_ok    = bus.imem_rsp_valid
             && (outstanding_q != '0);
    rsp_stray = bus.imem_rsp_valid
             && (outstanding_q == '0);
    pop       = bus.out_valid && bus.out_ready;

    if (rsp_stray) begin
      err_d = 1'b1;
    end

    if (redirect_valid) begin
      // Everything still in flight belongs to
      // the old path and must be discarded.
      fetch_pc_d    = redirect_base;
      rsp_pc_d      = redirect_base;
      fifo_count_d  = '0;
      rd_ptr_d      = '0;
      wr_ptr_d      = '0;
      outstanding_d = outstanding_q - CW'(rsp_ok);
      drop_cnt_d    = outstanding_q - CW'(rsp_ok);
    end else begin
      if (req_fire) begin
        fetch_pc_d = fetch_pc_q + PC_STEP;
      end
      outstanding_d = outstanding_q
                    + CW'(req_fire)
                    - CW'(rsp_ok);
      if (rsp_ok) begin
        if (drop_cnt_q != '0) begin
          drop_cnt_d = drop_cnt_q - CW'(1);
        end else begin
          push     = 1'b1;
          rsp_pc_d = rsp_pc_q + PC_STEP;
        end
      end
      if (push) begin
        wr_ptr_d = wr_ptr_q + AW'(1);
      end
      if (pop) begin
        rd_ptr_d = rd_ptr_q + AW'(1);
      end
      fifo_count_d = fifo_count_q
                   + FW'(push)
                   - FW'(pop);
    end
  end

  // Control state registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fetch_pc_q    <= RESET_PC;
      rsp_pc_q      <= RESET_PC;
      outstanding_q <= '0;
      drop_cnt_q    <= '0;
      fifo_count_q  <= '0;
      rd_ptr_q      <= '0;
      wr_ptr_q      <= '0;
      err_q         <= 1'b0;
    end else begin
      fetch_pc_q    <= fetch_pc_d;
      rsp_pc_q      <= rsp_pc_d;
      outstanding_q <= outstanding_d;
      drop_cnt_q    <= drop_cnt_d;
      fifo_count_q  <= fifo_count_d;
      rd_ptr_q      <= rd_ptr_d;
      wr_ptr_q      <= wr_ptr_d;
      err_q         <= err_d;
    end
  end

  // Prefetch FIFO storage: instruction word with its PC.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        instr_mem_q[i] <= '0;
        pc_mem_q[i]    <= '0;
      end
    end else if (push) begin
      instr_mem_q[wr_ptr_q] <= bus.imem_rsp_data;
      pc_mem_q[wr_ptr_q]    <= rsp_pc_q;
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: directed scenarios against a small
// in-order instruction memory with programmable latency.
module tb_fetch_unit;

  localparam logic [31:0] RPC = 32'h100;

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] due;
  } mreq_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = '0;
  logic        err;

  int checks   = 0;
  int failures = 0;

  fetch_unit_if #(.XLEN(32), .ILEN(32)) bus ();

  fetch_unit #(
    .XLEN(32),
    .ILEN(32),
    .RESET_PC(RPC),
    .FIFO_DEPTH(4),
    .MAX_OUTSTANDING(4)
  ) dut (
    .clk(clk),
    .rst(rst),
    .redirect_valid(redirect_valid),
    .redirect_pc(redirect_pc),
    .bus(bus),
    .err(err)
  );

  always #5 clk = ~clk;

  mreq_t       pend[$];
  logic [31:0] cyc = '0;
  logic [31:0] lat = 32'd1;
  logic        m_rsp_v = 1'b0;
  logic [31:0] m_rsp_d = '0;
  logic        man_en = 1'b0;
  logic        man_v = 1'b0;

  assign bus.imem_rsp_valid = man_en ? man_v : m_rsp_v;
  assign bus.imem_rsp_data  = m_rsp_d;

  function automatic logic [31:0] mdata(
    input logic [31:0] a);
    return ~a;
  endfunction

  // Memory: answer in order once the latency has elapsed.
  always begin
    @(posedge clk);
    #1;
    cyc = cyc + 32'd1;
    m_rsp_v = 1'b0;
    if (rst) begin
      pend.delete();
    end else if (pend.size() > 0) begin
      if (pend[0].due <= cyc) begin
        m_rsp_v = 1'b1;
        m_rsp_d = mdata(pend[0].addr);
        void'(pend.pop_front());
      end
    end
  end

  // Memory: accept requests.
  always @(negedge clk) begin
    if (!rst && bus.imem_req_valid
        && bus.imem_req_ready) begin
      pend.push_back('{addr: bus.imem_req_addr,
                       due: cyc + lat});
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout required finish");
    $fatal(1);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    redirect_valid = 1'b0;
    redirect_pc = '0;
    bus.imem_req_ready = 1'b1;
    bus.out_ready = 1'b1;
    man_en = 1'b0;
    man_v = 1'b0;
    lat = 32'd1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus.imem_req_ready = 1'b1;
    bus.out_ready = 1'b1;
    @(negedge clk);
    checks++;
    if (bus.imem_req_valid !== 1'b0) begin
      failures++;
      $display("FAIL rst_req_valid: got %b required 0",
               bus.imem_req_valid);
    end
    checks++;
    if (bus.out_valid !== 1'b0) begin
      failures++;
      $display("FAIL rst_out_valid: got %b required 0",
               bus.out_valid);
    end
    checks++;
    if (err !== 1'b0) begin
      failures++;
      $display("FAIL rst_err: got %b required 0", err);
    end
    do_reset();
    @(negedge clk);
    checks++;
    if (bus.imem_req_valid !== 1'b1
        || bus.imem_req_addr !== RPC) begin
      failures++;
      $display("FAIL rst_first_req: got %b/%h required 1/%h",
               bus.imem_req_valid, bus.imem_req_addr, RPC);
    end
    checks++;
    if (bus.out_valid !== 1'b0) begin
      failures++;
      $display("FAIL rst_empty: got %b required 0",
               bus.out_valid);
    end
  endtask

  task automatic test_stream();
    logic [31:0] ea;
    logic [31:0] ep;
    do_reset();
    lat = 32'd1;
    bus.out_ready = 1'b1;
    for (int k = 0; k < 8; k++) begin
      if (k > 0) tick();
      @(negedge clk);
      ea = RPC + 32'(4 * k);
      checks++;
      if (bus.imem_req_valid !== 1'b1
          || bus.imem_req_addr !== ea) begin
        failures++;
        $display("FAIL stream_req c%0d: got %b/%h required 1/%h",
                 k, bus.imem_req_valid, bus.imem_req_addr, ea);
      end
      if (k < 2) begin
        checks++;
        if (bus.out_valid !== 1'b0) begin
          failures++;
          $display("FAIL stream_lat c%0d: got %b required 0",
                   k, bus.out_valid);
        end
      end else begin
        ep = RPC + 32'(4 * (k - 2));
        checks++;
        if (bus.out_valid !== 1'b1
            || bus.out_pc !== ep
            || bus.out_instr !== mdata(ep)) begin
          failures++;
          $display("FAIL stream_out c%0d: got %b/%h/%h required 1/%h/%h",
                   k, bus.out_valid, bus.out_pc,
                   bus.out_instr, ep, mdata(ep));
        end
      end
    end
  endtask

  task automatic test_stall();
    int nreq;
    logic [31:0] ep;
    do_reset();
    lat = 32'd1;
    bus.out_ready = 1'b0;
    nreq = 0;
    for (int k = 0; k < 10; k++) begin
      if (k > 0) tick();
      @(negedge clk);
      if (bus.imem_req_valid && bus.imem_req_ready)
        nreq++;
    end
    checks++;
    if (nreq !== 4) begin
      failures++;
      $display("FAIL stall_reqs: got %0d required 4", nreq);
    end
    checks++;
    if (bus.imem_req_valid !== 1'b0) begin
      failures++;
      $display("FAIL stall_req_off: got %b required 0",
               bus.imem_req_valid);
    end
    checks++;
    if (bus.out_valid !== 1'b1 || bus.out_pc !== RPC
        || bus.out_instr !== mdata(RPC)) begin
      failures++;
      $display("FAIL stall_hold: got %b/%h/%h required 1/%h/%h",
               bus.out_valid, bus.out_pc, bus.out_instr,
               RPC, mdata(RPC));
    end
    tick();
    bus.out_ready = 1'b1;
    for (int j = 0; j < 5; j++) begin
      if (j > 0) tick();
      @(negedge clk);
      ep = RPC + 32'(4 * j);
      checks++;
      if (bus.out_valid !== 1'b1 || bus.out_pc !== ep
          || bus.out_instr !== mdata(ep)) begin
        failures++;
        $display("FAIL drain_out %0d: got %b/%h/%h required 1/%h/%h",
                 j, bus.out_valid, bus.out_pc,
                 bus.out_instr, ep, mdata(ep));
      end
      if (j == 0) begin
        checks++;
        if (bus.imem_req_valid !== 1'b0) begin
          failures++;
          $display("FAIL drain_req0: got %b required 0",
                   bus.imem_req_valid);
        end
      end
      if (j == 1) begin
        checks++;
        if (bus.imem_req_valid !== 1'b1
            || bus.imem_req_addr !== 32'h110) begin
          failures++;
          $display("FAIL drain_resume: got %b/%h required 1/00000110",
                   bus.imem_req_valid, bus.imem_req_addr);
        end
      end
    end
  endtask

  task automatic test_redirect();
    do_reset();
    lat = 32'd4;
    bus.out_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      if (k > 0) tick();
      @(negedge clk);
    end
    tick();
    bus.imem_req_ready = 1'b0;
    redirect_valid = 1'b1;
    redirect_pc = 32'h2003;
    @(negedge clk);
    checks++;
    if (bus.imem_req_valid !== 1'b0
        || bus.out_valid !== 1'b0) begin
      failures++;
      $display("FAIL redir_cycle: got req %b out %b required 0/0",
               bus.imem_req_valid, bus.out_valid);
    end
    tick();
    redirect_valid = 1'b0;
    bus.imem_req_ready = 1'b1;
    @(negedge clk);
    checks++;
    if (bus.imem_req_valid !== 1'b1
        || bus.imem_req_addr !== 32'h2000) begin
      failures++;
      $display("FAIL redir_addr: got %b/%h required 1/00002000",
               bus.imem_req_valid, bus.imem_req_addr);
    end
    for (int k = 5; k < 9; k++) begin
      tick();
      @(negedge clk);
      checks++;
      if (bus.out_valid !== 1'b0) begin
        failures++;
        $display("FAIL redir_stale c%0d: got %b/%h required 0",
                 k, bus.out_valid, bus.out_pc);
      end
    end
    tick();
    @(negedge clk);
    checks++;
    if (bus.out_valid !== 1'b1
        || bus.out_pc !== 32'h2000
        || bus.out_instr !== mdata(32'h2000)) begin
      failures++;
      $display("FAIL redir_first: got %b/%h/%h required 1/00002000/%h",
               bus.out_valid, bus.out_pc, bus.out_instr,
               mdata(32'h2000));
    end
    tick();
    @(negedge clk);
    checks++;
    if (bus.out_valid !== 1'b1
        || bus.out_pc !== 32'h2004) begin
      failures++;
      $display("FAIL redir_second: got %b/%h required 1/00002004",
               bus.out_valid, bus.out_pc);
    end
  endtask

  task automatic test_redirect_rsp();
    do_reset();
    lat = 32'd2;
    bus.out_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      if (k > 0) tick();
      @(negedge clk);
    end
    tick();
    bus.out_ready = 1'b1;
    redirect_valid = 1'b1;
    redirect_pc = 32'h3000;
    @(negedge clk);
    checks++;
    if (bus.out_valid !== 1'b0
        || bus.imem_req_valid !== 1'b0) begin
      failures++;
      $display("FAIL rr_cycle: got out %b req %b required 0/0",
               bus.out_valid, bus.imem_req_valid);
    end
    tick();
    redirect_valid = 1'b0;
    @(negedge clk);
    checks++;
    if (bus.imem_req_valid !== 1'b1
        || bus.imem_req_addr !== 32'h3000
        || bus.out_valid !== 1'b0) begin
      failures++;
      $display("FAIL rr_resume: got %b/%h out %b required 1/00003000 out 0",
               bus.imem_req_valid, bus.imem_req_addr,
               bus.out_valid);
    end
    for (int k = 5; k < 7; k++) begin
      tick();
      @(negedge clk);
      checks++;
      if (bus.out_valid !== 1'b0) begin
        failures++;
        $display("FAIL rr_drop c%0d: got %b/%h required 0",
                 k, bus.out_valid, bus.out_pc);
      end
    end
    tick();
    @(negedge clk);
    checks++;
    if (bus.out_valid !== 1'b1
        || bus.out_pc !== 32'h3000
        || bus.out_instr !== mdata(32'h3000)) begin
      failures++;
      $display("FAIL rr_first: got %b/%h/%h required 1/00003000/%h",
               bus.out_valid, bus.out_pc, bus.out_instr,
               mdata(32'h3000));
    end
  endtask

  task automatic test_wrap();
    logic [31:0] ea;
    logic [31:0] ep;
    do_reset();
    lat = 32'd1;
    bus.out_ready = 1'b1;
    redirect_valid = 1'b1;
    redirect_pc = 32'hFFFF_FFF9;
    @(negedge clk);
    tick();
    redirect_valid = 1'b0;
    for (int k = 1; k < 7; k++) begin
      if (k > 1) tick();
      @(negedge clk);
      if (k <= 4) begin
        ea = 32'hFFFF_FFF8 + 32'(4 * (k - 1));
        checks++;
        if (bus.imem_req_valid !== 1'b1
            || bus.imem_req_addr !== ea) begin
          failures++;
          $display("FAIL wrap_req c%0d: got %b/%h required 1/%h",
                   k, bus.imem_req_valid,
                   bus.imem_req_addr, ea);
        end
      end
      if (k >= 3) begin
        ep = 32'hFFFF_FFF8 + 32'(4 * (k - 3));
        checks++;
        if (bus.out_valid !== 1'b1
            || bus.out_pc !== ep
            || bus.out_instr !== mdata(ep)) begin
          failures++;
          $display("FAIL wrap_out c%0d: got %b/%h/%h required 1/%h/%h",
                   k, bus.out_valid, bus.out_pc,
                   bus.out_instr, ep, mdata(ep));
        end
      end
    end
    checks++;
    if (err !== 1'b0) begin
      failures++;
      $display("FAIL wrap_err: got %b required 0", err);
    end
  endtask

  task automatic test_mid_reset();
    do_reset();
    lat = 32'd1;
    bus.out_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      if (k > 0) tick();
      @(negedge clk);
    end
    tick();
    checks++;
    if (bus.out_valid !== 1'b1 || bus.out_pc !== RPC) begin
      failures++;
      $display("FAIL mr_pre: got %b/%h required 1/%h",
               bus.out_valid, bus.out_pc, RPC);
    end
    #1;
    rst = 1'b1;
    #1;
    checks++;
    if (bus.out_valid !== 1'b0
        || bus.imem_req_valid !== 1'b0) begin
      failures++;
      $display("FAIL mr_async: got out %b req %b required 0/0",
               bus.out_valid, bus.imem_req_valid);
    end
    repeat (2) @(posedge clk);
    #1;
    bus.imem_req_ready = 1'b0;
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if (bus.out_valid !== 1'b0 || err !== 1'b0
        || bus.imem_req_valid !== 1'b1
        || bus.imem_req_addr !== RPC) begin
      failures++;
      $display("FAIL mr_after: got out %b err %b req %b/%h required 0 0 1/%h",
               bus.out_valid, err, bus.imem_req_valid,
               bus.imem_req_addr, RPC);
    end
    tick();
    man_en = 1'b1;
    man_v = 1'b1;
    @(negedge clk);
    tick();
    man_v = 1'b0;
    @(negedge clk);
    checks++;
    if (err !== 1'b1 || bus.out_valid !== 1'b0) begin
      failures++;
      $display("FAIL mr_stray: got err %b out %b required 1/0",
               err, bus.out_valid);
    end
    tick();
    @(negedge clk);
    checks++;
    if (err !== 1'b1 || bus.out_valid !== 1'b0) begin
      failures++;
      $display("FAIL mr_sticky: got err %b out %b required 1/0",
               err, bus.out_valid);
    end
    do_reset();
    @(negedge clk);
    checks++;
    if (err !== 1'b0) begin
      failures++;
      $display("FAIL mr_err_clear: got %b required 0", err);
    end
  endtask

  initial begin
    bus.imem_req_ready = 1'b1;
    bus.out_ready = 1'b1;
    test_reset();
    test_stream();
    test_stall();
    test_redirect();
    test_redirect_rsp();
    test_wrap();
    test_mid_reset();
    $display("TB_RESULT checks=%0d failures=%0d",
             checks, failures);
    $finish;
  end

endmodule
